scan_chain_responder: RTL

//  Target end of the AES scan-chain test interface. Deserialises the 387-bit chain
//  {i_text[127:0], key[255:0], pt_sel, key_sel, ct_out_sel} from scan_in into shadow registers.

---
 rtl/scan_chain_responder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/scan_chain_responder.sv
// AES scan-chain target: deserialises the config chain, starts the core, captures its result.
// Optional `SCAN_LEN_CHECK_EN rejects updates whose shift count differs from CHAIN_W.
module scan_chain_responder #(
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned KEY_W    = 256,
    parameter int unsigned CHAIN_W  = DATA_W + KEY_W + 3,
    parameter int unsigned TRIG_LEN = 4,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               scan_en,
    input  logic               scan_in,
    output logic               scan_out,
    input  logic               update_i,
    output logic [DATA_W-1:0]  i_text_o,
    output logic [KEY_W-1:0]   key_o,
    output logic               pt_sel_o,
    output logic               key_sel_o,
    output logic               ct_out_sel_o,
    output logic               start_o,
    input  logic               core_done_i,
    input  logic [DATA_W-1:0]  core_data_i,
    output logic               trigger_o,
    output logic [CHAIN_W-1:0] sc_out_o,
    output logic               busy_o,
    output logic               err_o
);
    localparam int unsigned TrigW = $clog2(TRIG_LEN + 1);
    localparam int unsigned ToW   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StTrig1, StRun, StGap, StTrig2, StDone} state_e;

    state_e             state_q;
    logic [TrigW-1:0]   trig_cnt_q;
    logic [ToW-1:0]     to_cnt_q;
    logic               done_pend_q;
    logic [DATA_W-1:0]  core_data_q;
    logic [CHAIN_W-1:0] sr_q;

    logic ready, len_ok, accept, reject, shift, trig_last, to_hit;

    assign ready     = (state_q == StIdle) || (state_q == StDone);
    assign accept    = ready && update_i && len_ok;
    assign reject    = ready && update_i && !len_ok;
    assign shift     = ready && scan_en && !update_i;
    assign trig_last = (trig_cnt_q == TrigW'(TRIG_LEN - 1));
    assign to_hit    = (to_cnt_q == ToW'(TIMEOUT - 1));
    assign scan_out  = sr_q[CHAIN_W-1];
    assign sc_out_o  = sr_q;

`ifdef SCAN_LEN_CHECK_EN
    logic [8:0] len_cnt_q;

    assign len_ok = (len_cnt_q == 9'(CHAIN_W));

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            len_cnt_q <= '0;
        end else if (shift && (len_cnt_q != 9'(CHAIN_W + 1))) begin
            len_cnt_q <= len_cnt_q + 9'd1;
        end
    end
`else
    assign len_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            trig_cnt_q   <= '0;
            to_cnt_q     <= '0;
            done_pend_q  <= 1'b0;
            core_data_q  <= '0;
            sr_q         <= '0;
            i_text_o     <= '0;
            key_o        <= '0;
            pt_sel_o     <= 1'b0;
            key_sel_o    <= 1'b0;
            ct_out_sel_o <= 1'b0;
            start_o      <= 1'b0;
            trigger_o    <= 1'b0;
            busy_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            start_o <= 1'b0;
            if (shift) begin
                sr_q <= {sr_q[CHAIN_W-2:0], scan_in};
            end
            if (accept) begin
                i_text_o     <= sr_q[CHAIN_W-1 -: DATA_W];
                key_o        <= sr_q[KEY_W+2:3];
                pt_sel_o     <= sr_q[2];
                key_sel_o    <= sr_q[1];
                ct_out_sel_o <= sr_q[0];
                start_o      <= 1'b1;
                busy_o       <= 1'b1;
                trigger_o    <= 1'b1;
                err_o        <= 1'b0;
                trig_cnt_q   <= '0;
                to_cnt_q     <= '0;
                done_pend_q  <= 1'b0;
                state_q      <= StTrig1;
            end else if (reject) begin
                err_o <= 1'b1;
            end

            case (state_q)
                StTrig1: begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                    // Hold an early result until the first trigger pulse has finished
                    if (core_done_i && !done_pend_q) begin
                        done_pend_q <= 1'b1;
                        core_data_q <= core_data_i;
                    end
                    if (to_hit && !done_pend_q && !core_done_i) begin
                        err_o     <= 1'b1;
                        busy_o    <= 1'b0;
                        trigger_o <= 1'b0;
                        state_q   <= StDone;
                    end else if (trig_last) begin
                        trigger_o <= 1'b0;
                        state_q   <= (done_pend_q || core_done_i) ? StGap : StRun;
                    end else begin
                        trig_cnt_q <= trig_cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                    if (core_done_i) begin
                        core_data_q <= core_data_i;
                        state_q     <= StGap;
                    end else if (to_hit) begin
                        err_o   <= 1'b1;
                        busy_o  <= 1'b0;
                        state_q <= StDone;
                    end
                end
                StGap: begin
                    if (ct_out_sel_o) begin
                        sr_q[DATA_W-1:0] <= core_data_q;
                    end
                    trigger_o  <= 1'b1;
                    trig_cnt_q <= '0;
                    state_q    <= StTrig2;
                end
                StTrig2: begin
                    if (trig_last) begin
                        trigger_o <= 1'b0;
                        busy_o    <= 1'b0;
                        state_q   <= StDone;
                    end else begin
                        trig_cnt_q <= trig_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
